// File: rtl/buffer_loader_pkg.sv
// buffer_loader_pkg: constants and state encoding for the frame-buffer write
// sequencer. The constants size the 128 x 32 frame buffer and are shared with
// whatever instantiates that buffer next to the loader.
package buffer_loader_pkg;

  localparam int unsigned DEPTH  = 128;  // buffer entries, max frame length
  localparam int unsigned ADDR_W = 7;    // log2(DEPTH)
  localparam int unsigned DATA_W = 32;   // word width

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FLUSH,
    PUBLISH
  } loader_state_t;

endpackage

// File: rtl/buffer_loader.sv
// buffer_loader: write-side sequencer for the AES frame buffer.
// Accepts a valid/ready word stream, writes consecutive buffer addresses from
// 0, closes a frame on s_last or when DEPTH words have been written, then holds
// en_read until the engine acknowledges the published frame.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   s_valid/s_data/s_last input word stream; s_ready back-pressure
//   address/data/en_write registered buffer write port
//   en_read               buffer read enable, high for the publish phase
//   frame_valid           buffer parallel outputs hold the current frame
//   frame_len             words in the published frame (1..DEPTH)
//   frame_trunc           frame closed at DEPTH words without s_last
//   consume_ack           engine is done with the frame
module buffer_loader
  import buffer_loader_pkg::*;
#(
  parameter int unsigned DEPTH  = buffer_loader_pkg::DEPTH,
  parameter int unsigned ADDR_W = buffer_loader_pkg::ADDR_W,
  parameter int unsigned DATA_W = buffer_loader_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              en_write,
  output logic              en_read,
  output logic              frame_valid,
  output logic [ADDR_W:0]   frame_len,
  output logic              frame_trunc,
  input  logic              consume_ack
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  loader_state_t     state, state_next;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W:0]   count, count_inc;
  logic              accept, close;

  always_comb begin
    s_ready    = (state == IDLE) || (state == FILL);
    accept     = s_valid && s_ready;
    count_inc  = count + 1'b1;
    close      = accept && (s_last || (count_inc == DEPTH_CNT));
    state_next = state;
    case (state)
      IDLE, FILL: if (accept) state_next = close ? FLUSH : FILL;
      FLUSH:      state_next = PUBLISH;
      PUBLISH:    if (frame_valid && consume_ack) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr        <= '0;
      count       <= '0;
      address     <= '0;
      data        <= '0;
      en_write    <= 1'b0;
      en_read     <= 1'b0;
      frame_valid <= 1'b0;
      frame_len   <= '0;
      frame_trunc <= 1'b0;
    end else begin
      // Write strobe follows accepts one cycle later; address/data hold otherwise.
      en_write <= accept;
      if (accept) begin
        address <= wptr;
        data    <= s_data;
        if (close) begin
          // Pointer and count restart here so IDLE always begins from zero.
          wptr        <= '0;
          count       <= '0;
          frame_len   <= count_inc;
          frame_trunc <= (count_inc == DEPTH_CNT) && !s_last;
        end else begin
          wptr  <= wptr + 1'b1;
          count <= count_inc;
        end
      end

      if (state == FLUSH) en_read <= 1'b1;

      // Buffer outputs are registered, so frame_valid lags en_read by a cycle
      // and an ack arriving before that is ignored.
      if (state == PUBLISH) begin
        if (!frame_valid) begin
          frame_valid <= 1'b1;
        end else if (consume_ack) begin
          en_read     <= 1'b0;
          frame_valid <= 1'b0;
          frame_trunc <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/buffer_loader.md
# buffer_loader

Write-side sequencer for the 128 x 32 frame buffer in the RV32 AES datapath. It accepts a valid/ready stream of 32-bit words from the core/DMA side and drives the buffer's `address`/`data`/`en_write` port with consecutive addresses from 0. When a frame closes, it holds the buffer's `en_read` so the AES engine sees the whole frame on the parallel outputs. It then waits for the engine's acknowledge before accepting the next frame.

## Interface
- `DEPTH`, 128: buffer entries; maximum frame length in words.
- `ADDR_W`, 7: buffer address width, log2(DEPTH).
- `DATA_W`, 32: word width.

- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  input word valid.
- `s_data`  in  DATA_W  input word.
- `s_last`  in  1  final word of frame, qualified by `s_valid`.
- `s_ready`  out  1  loader can accept a word.
- `address`  out  ADDR_W  buffer write address (registered).
- `data`  out  DATA_W  buffer write data (registered).
- `en_write`  out  1  buffer write strobe (registered).
- `en_read`  out  1  buffer read enable; held high for the whole publish phase.
- `frame_valid`  out  1  buffer parallel outputs hold the current frame.
- `frame_len`  out  ADDR_W+1  number of words in the published frame, 1..DEPTH.
- `frame_trunc`  out  1  frame closed at DEPTH words without `s_last`.
- `consume_ack`  in  1  engine has finished with the frame; release the buffer.

## Operation
- FSM states: IDLE, FILL, FLUSH, PUBLISH.
- Handshake: a beat is accepted when `s_valid && s_ready`. `s_ready` = 1 in IDLE and FILL, 0 in FLUSH and PUBLISH.
- IDLE:
  - Write pointer `wptr` = 0 and word count = 0.
  - On the first accepted beat, register `address` = 0, `data` = `s_data`, `en_write` = 1, `wptr` = 1, count = 1.
  - Next state is FILL, or FLUSH if `s_last` is set.
- FILL:
  - Each accepted beat registers `address` = `wptr`, `data` = `s_data`, `en_write` = 1. Then `wptr`++ and count++.
  - A cycle with no accepted beat registers `en_write` = 0; `address`/`data` hold.
- Frame close: the accepted beat has `s_last` = 1, or count reaches DEPTH (`wptr` wraps to 0).
  - Go to FLUSH.
  - Latch `frame_len` = count, including the closing beat.
  - Latch `frame_trunc` = 1 if count == DEPTH and `s_last` = 0 on the closing beat; otherwise 0.
- `s_last` on the DEPTH-th word is a normal close, with `frame_trunc` = 0.
- Words after a truncated close are not dropped; they stall on `s_ready` = 0 and start the next frame.
- FLUSH (1 cycle): the last `en_write` is presented and the write lands at the end of this cycle. `en_write` is registered to 0 and the state goes to PUBLISH.
- PUBLISH:
  - `en_read` = 1.
  - `frame_valid` = 1 from the second PUBLISH cycle onward, because the buffer outputs are registered.
  - `consume_ack` is ignored while `frame_valid` = 0.
  - `consume_ack` with `frame_valid` = 1 sends the state to IDLE. `en_read`, `frame_valid` and `frame_trunc` drop to 0 at that edge. `frame_len` holds its value until the next close.
- Buffer entries at or above `frame_len` are stale from earlier frames. The consumer qualifies them with `frame_len`; the loader never clears the buffer.
- Reset, including mid-FILL or mid-PUBLISH:
  - State goes to IDLE; `wptr` and count go to 0.
  - Outputs reset to `s_ready` = 1, `address` = 0, `data` = 0, `en_write` = 0, `en_read` = 0, `frame_valid` = 0, `frame_len` = 0, `frame_trunc` = 0.
  - A partial frame is abandoned.

## Timing
- Beat accepted at edge k: `en_write`/`address`/`data` are valid during cycle k+1, and the buffer is written at edge k+1.
- Closing beat at edge k:
  - FLUSH in cycle k+1.
  - `en_read` = 1 in cycle k+2.
  - Buffer outputs update at edge k+2.
  - `frame_valid` = 1 in cycle k+3.
- Minimum gap from `consume_ack` (edge a) to the next accepted beat: `s_ready` = 1 in cycle a+1.
- Streaming throughput: one word per cycle in IDLE/FILL. Per-frame overhead is FLUSH + 2 cycles + ack wait.

## Structure
- `buffer_loader_pkg` holds:
  - `DEPTH`, `ADDR_W`, `DATA_W` constants, shared with the buffer instantiation in the top level.
  - The `loader_state_t` enum {IDLE, FILL, FLUSH, PUBLISH}.
- No sub-module: the counter, FSM and write register stage are a single module.
- The top level inverts `reset` to drive the buffer's active-low reset.

## Test plan
- Frame of 4 words (0xA0..0xA3, `s_last` on the 4th), `s_valid` continuous:
  - `address` goes 0,1,2,3 with `en_write` high for 4 cycles.
  - `en_read` rises 2 cycles after the last accept; `frame_valid` rises 1 cycle later.
  - `frame_len` = 4, `frame_trunc` = 0, buffer out0..out3 = 0xA0..0xA3.
- 130 words with no `s_last`:
  - First frame closes at 128 with `frame_trunc` = 1, `frame_len` = 128, and `s_ready` = 0.
  - After `consume_ack`, words 129-130 write to addresses 0-1.
- 128 words with `s_last` on word 128: `frame_trunc` = 0, `frame_len` = 128.
- `s_valid` toggling 1,0,0,1,1 over a 3-word frame: `en_write` only in the cycles after accepts, and addresses stay contiguous 0,1,2.
- `consume_ack` pulsed in the first PUBLISH cycle (`frame_valid` = 0):
  - The ack is ignored and the state stays PUBLISH.
  - A second ack with `frame_valid` = 1 returns to IDLE: `en_read` = 0, `s_ready` = 1.
- `reset` asserted after 5 of 10 words:
  - All outputs go to their reset values.
  - A new 2-word frame starts at address 0, with `frame_len` = 2.
